id_stage_ctrl: RTL and testbench
================================

Name: id_stage_ctrl

Overview:
- Decode-stage sequencer for the in-order pipeline.
- Owns the IF/ID register and drives the immediate extender: 3-bit imm source select plus the 25-bit instruction field instr[31:7].
- Detects load-use hazards, inserts one-cycle bubbles and handles EX-stage redirect flushes.
- Registers the ID/EX control bundle consumed by the execute stage.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on reset or flush (addi x0,x0,0).
- IGNORE_X0, 1, when 1 a load whose destination is x0 never causes a stall.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- f_instr  in  32  fetched instruction.
- f_pc  in  32  PC of the fetched instruction.
- f_valid  in  1  fetch slot holds a real instruction.
- ex_redirect  in  1  taken branch/jump resolved in EX; flushes IF/ID and ID/EX.
- f_stall  out  1  hold PC and fetch output this cycle.
- d_imm  out  25  IF/ID instr[31:7], to the extender imm input.
- d_immsrc  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U.
- d_rs1  out  5  IF/ID instr[19:15].
- d_rs2  out  5  IF/ID instr[24:20].
- e_valid  out  1  ID/EX slot holds a real instruction.
- e_pc  out  32  ID/EX PC.
- e_rd  out  5  ID/EX destination register.
- e_immsrc  out  3  ID/EX copy of the imm select.
- e_regwrite  out  1  ID/EX register-write enable.
- e_memread  out  1  ID/EX load flag.
- e_memwrite  out  1  ID/EX store flag.
- e_illegal  out  1  ID/EX holds an unrecognised opcode.
- bubble_st  out  1  FSM is in BUBBLE.

Behaviour:
- Reset (next edge with rst=1):
  - IF/ID: instr=NOP_INSTR, pc=0, valid=0.
  - ID/EX: all fields 0.
  - FSM goes to RUN.
  - f_stall=0 while rst is high.
- Decode is combinational from IF/ID, opcode instr[6:0]:
  - 0000011 LOAD: I; memread, regwrite; uses rs1.
  - 0010011 OP-IMM: I; regwrite; uses rs1.
  - 1100111 JALR: I; regwrite; uses rs1.
  - 0100011 STORE: S; memwrite; uses rs1 and rs2.
  - 1100011 BRANCH: B; no writes; uses rs1 and rs2.
  - 1101111 JAL: J; regwrite; no sources.
  - 0110111 LUI and 0010111 AUIPC: U; regwrite; no sources.
  - 0110011 OP: immsrc 000 (unused); regwrite; uses rs1 and rs2.
  - Any other opcode: immsrc 000, all controls 0, illegal=1.
- d_imm and d_immsrc are always driven from IF/ID; the extender result is valid in the same cycle (0 added latency).
- hazard = IF/ID valid & e_valid & e_memread & (e_rd != 0 or IGNORE_X0 == 0) & ((rs1 used & d_rs1 == e_rd) | (rs2 used & d_rs2 == e_rd)).
- Per-edge update, priority order:
  1. rst: reset as above.
  2. ex_redirect: IF/ID <- NOP_INSTR with valid 0; ID/EX <- all zero; FSM -> RUN; f_stall=0 this cycle.
  3. hazard & FSM == RUN: f_stall=1; IF/ID holds; ID/EX <- bubble (all zero); FSM -> BUBBLE.
  4. Otherwise: IF/ID <- f_instr, f_pc, f_valid; ID/EX <- decoded bundle (e_valid = IF/ID valid); FSM -> RUN.
- FSM states:
  - RUN: normal flow.
  - BUBBLE: exactly one cycle after a bubble insert. hazard is masked in BUBBLE, so the stall length is always exactly 1 cycle. Leaves for RUN on the next edge unconditionally.
- Invalid IF/ID slot (valid=0): never raises hazard; ID/EX gets e_valid=0 with controls 0.
- Illegal instruction: e_valid=1, e_illegal=1, regwrite/memread/memwrite all 0; it does not stall.
- e_immsrc is a registered copy of d_immsrc; bubbles load 000.

Test Plan:
- Reset: hold rst 2 cycles with f_valid=1 -> e_valid=0, f_stall=0, d_imm = NOP_INSTR[31:7] = 25'h000_0000 (NOP_INSTR[31:7] is all zero), d_immsrc=000, bubble_st=0.
- Imm select sweep: feed 0x00A00093 (addi), 0x00112223 (sw), 0x00208463 (beq), 0x008000EF (jal), 0x123450B7 (lui):
  - d_immsrc = 000, 001, 010, 011, 100 respectively.
  - d_imm = instr[31:7]; e_immsrc follows one cycle later.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> f_stall=1 for exactly 1 cycle; bubble (e_valid=0) in EX; bubble_st=1 the next cycle; the add reaches EX with e_rd=6, e_regwrite=1.
- x0 / non-use: lw x0,0(x1) then add x6,x0,x2 -> no stall (IGNORE_X0=1). lw x5 then lui x5 -> no stall (U uses no sources).
- Redirect during hazard: load-use pair with ex_redirect=1 in the hazard cycle -> f_stall=0; IF/ID and ID/EX flushed (e_valid=0 next cycle); FSM RUN.
- Illegal and mid-stall reset:
  - Opcode 0x7F -> e_valid=1, e_illegal=1, all writes 0.
  - Assert rst while bubble_st=1 -> all outputs zero and FSM RUN after that edge.

Source files
------------

// File: rtl/id_stage_ctrl_if.sv
// Fetch/decode/execute-facing signal bundle of the decode-stage sequencer.
// The slave modport is the sequencer; the master modport is whoever drives fetch and observes EX.
interface id_stage_ctrl_if;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        ex_redirect;
  logic        f_stall;
  logic [24:0] d_imm;
  logic [2:0]  d_immsrc;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [4:0]  e_rd;
  logic [2:0]  e_immsrc;
  logic        e_regwrite;
  logic        e_memread;
  logic        e_memwrite;
  logic        e_illegal;
  logic        bubble_st;

  modport master (
    output f_instr, f_pc, f_valid, ex_redirect,
    input  f_stall, d_imm, d_immsrc, d_rs1, d_rs2, e_valid, e_pc, e_rd,
           e_immsrc, e_regwrite, e_memread, e_memwrite, e_illegal, bubble_st
  );

  modport slave (
    input  f_instr, f_pc, f_valid, ex_redirect,
    output f_stall, d_imm, d_immsrc, d_rs1, d_rs2, e_valid, e_pc, e_rd,
           e_immsrc, e_regwrite, e_memread, e_memwrite, e_illegal, bubble_st
  );
endinterface

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: owns IF/ID, drives the immediate extender, inserts
// one-cycle load-use bubbles, handles EX redirect flushes and registers ID/EX.
module id_stage_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit          IGNORE_X0 = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_ctrl_if.slave bus
);

  typedef enum logic {RUN, BUBBLE} state_e;

  typedef struct packed {
    logic [2:0] immsrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       use_rs1;
    logic       use_rs2;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  immsrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        illegal;
  } idex_t;

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      7'b0000011: begin d.memread = 1'b1; d.regwrite = 1'b1; d.use_rs1 = 1'b1; end
      7'b0010011,
      7'b1100111: begin d.regwrite = 1'b1; d.use_rs1 = 1'b1; end
      7'b0100011: begin d.immsrc = 3'b001; d.memwrite = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      7'b1100011: begin d.immsrc = 3'b010; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      7'b1101111: begin d.immsrc = 3'b011; d.regwrite = 1'b1; end
      7'b0110111,
      7'b0010111: begin d.immsrc = 3'b100; d.regwrite = 1'b1; end
      7'b0110011: begin d.regwrite = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic        ifid_valid_q;
  idex_t       ex_q;
  idex_t       ex_d;
  state_e      state_q;
  dec_t        dec;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        stall_ins;

  // ---- ID: combinational decode from IF/ID ----
  always_comb begin
    dec    = decode(ifid_instr_q[6:0]);
    rs1    = ifid_instr_q[19:15];
    rs2    = ifid_instr_q[24:20];
    hazard = ifid_valid_q && ex_q.valid && ex_q.memread &&
             (ex_q.rd != 5'd0 || !IGNORE_X0) &&
             ((dec.use_rs1 && rs1 == ex_q.rd) || (dec.use_rs2 && rs2 == ex_q.rd));
    // Hazard is masked in BUBBLE, which bounds every stall to one cycle.
    stall_ins = hazard && (state_q == RUN);

    ex_d = '0;
    if (ifid_valid_q) begin
      ex_d.valid    = 1'b1;
      ex_d.pc       = ifid_pc_q;
      ex_d.rd       = ifid_instr_q[11:7];
      ex_d.immsrc   = dec.immsrc;
      ex_d.regwrite = dec.regwrite;
      ex_d.memread  = dec.memread;
      ex_d.memwrite = dec.memwrite;
      ex_d.illegal  = dec.illegal;
    end
  end

  // ---- IF/ID, ID/EX and sequencer state ----
  always_ff @(posedge clk) begin
    if (rst || bus.ex_redirect) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ex_q         <= '0;
      state_q      <= RUN;
    end else if (stall_ins) begin
      ex_q    <= '0;
      state_q <= BUBBLE;
    end else begin
      ifid_instr_q <= bus.f_instr;
      ifid_pc_q    <= bus.f_pc;
      ifid_valid_q <= bus.f_valid;
      ex_q         <= ex_d;
      state_q      <= RUN;
    end
  end

  assign bus.f_stall    = !rst && !bus.ex_redirect && stall_ins;
  assign bus.d_imm      = ifid_instr_q[31:7];
  assign bus.d_immsrc   = dec.immsrc;
  assign bus.d_rs1      = rs1;
  assign bus.d_rs2      = rs2;
  assign bus.e_valid    = ex_q.valid;
  assign bus.e_pc       = ex_q.pc;
  assign bus.e_rd       = ex_q.rd;
  assign bus.e_immsrc   = ex_q.immsrc;
  assign bus.e_regwrite = ex_q.regwrite;
  assign bus.e_memread  = ex_q.memread;
  assign bus.e_memwrite = ex_q.memwrite;
  assign bus.e_illegal  = ex_q.illegal;
  assign bus.bubble_st  = (state_q == BUBBLE);

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed scenarios plus random traffic, all checked
// against a table-driven pipeline model.
module tb_id_stage_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_ctrl_if bus();
  id_stage_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0] imm;
    logic rw, mr, mw, u1, u2;
  } info_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  imm;
    logic        rw, mr, mw, ill;
  } ex_t;

  info_t tbl [logic [6:0]];

  logic [31:0] m_if_instr;
  logic [31:0] m_if_pc;
  logic        m_if_valid;
  ex_t         m_ex;
  bit          m_bub;
  int          errors = 0;
  int          checks = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic info_t lookup(input logic [6:0] op, output bit legal);
    legal = tbl.exists(op);
    return legal ? tbl[op] : info_t'('0);
  endfunction

  function automatic bit model_hazard();
    bit    legal;
    info_t i;
    logic [4:0] r1, r2;
    i  = lookup(m_if_instr[6:0], legal);
    r1 = m_if_instr[19:15];
    r2 = m_if_instr[24:20];
    return m_if_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) &&
           ((i.u1 && r1 == m_ex.rd) || (i.u2 && r2 == m_ex.rd));
  endfunction

  task automatic check_all();
    bit    legal;
    info_t i;
    i = lookup(m_if_instr[6:0], legal);
    cmp("f_stall",    32'(bus.f_stall),    32'(!rst && !bus.ex_redirect && model_hazard() && !m_bub));
    cmp("d_imm",      32'(bus.d_imm),      32'(m_if_instr[31:7]));
    cmp("d_immsrc",   32'(bus.d_immsrc),   32'(i.imm));
    cmp("d_rs1",      32'(bus.d_rs1),      32'(m_if_instr[19:15]));
    cmp("d_rs2",      32'(bus.d_rs2),      32'(m_if_instr[24:20]));
    cmp("e_valid",    32'(bus.e_valid),    32'(m_ex.valid));
    cmp("e_pc",       bus.e_pc,            m_ex.pc);
    cmp("e_rd",       32'(bus.e_rd),       32'(m_ex.rd));
    cmp("e_immsrc",   32'(bus.e_immsrc),   32'(m_ex.imm));
    cmp("e_regwrite", 32'(bus.e_regwrite), 32'(m_ex.rw));
    cmp("e_memread",  32'(bus.e_memread),  32'(m_ex.mr));
    cmp("e_memwrite", 32'(bus.e_memwrite), 32'(m_ex.mw));
    cmp("e_illegal",  32'(bus.e_illegal),  32'(m_ex.ill));
    cmp("bubble_st",  32'(bus.bubble_st),  32'(m_bub));
  endtask

  task automatic model_reset();
    m_if_instr = NOP; m_if_pc = '0; m_if_valid = 1'b0; m_ex = '0; m_bub = 1'b0;
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_next(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                            input logic redir, input logic r);
    bit    legal;
    info_t i;
    if (r || redir) begin
      model_reset();
    end else if (model_hazard() && !m_bub) begin
      m_ex  = '0;
      m_bub = 1'b1;
    end else begin
      i = lookup(m_if_instr[6:0], legal);
      m_ex = '0;
      if (m_if_valid) begin
        m_ex.valid = 1'b1;
        m_ex.pc    = m_if_pc;
        m_ex.rd    = m_if_instr[11:7];
        m_ex.imm   = i.imm;
        m_ex.rw    = i.rw;
        m_ex.mr    = i.mr;
        m_ex.mw    = i.mw;
        m_ex.ill   = !legal;
      end
      m_if_instr = ins; m_if_pc = pc; m_if_valid = v; m_bub = 1'b0;
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic redir, input logic r);
    @(negedge clk);
    bus.f_instr = ins; bus.f_pc = pc; bus.f_valid = v; bus.ex_redirect = redir; rst = r;
    #1;
    check_all();
    model_next(ins, pc, v, redir, r);
  endtask

  logic [31:0] sweep [5];
  logic [2:0]  sweep_sel [5];
  logic [6:0]  pool [10];

  initial begin
    tbl[7'b0000011] = '{imm:3'd0, rw:1'b1, mr:1'b1, mw:1'b0, u1:1'b1, u2:1'b0};
    tbl[7'b0010011] = '{imm:3'd0, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b1, u2:1'b0};
    tbl[7'b1100111] = '{imm:3'd0, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b1, u2:1'b0};
    tbl[7'b0100011] = '{imm:3'd1, rw:1'b0, mr:1'b0, mw:1'b1, u1:1'b1, u2:1'b1};
    tbl[7'b1100011] = '{imm:3'd2, rw:1'b0, mr:1'b0, mw:1'b0, u1:1'b1, u2:1'b1};
    tbl[7'b1101111] = '{imm:3'd3, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b0, u2:1'b0};
    tbl[7'b0110111] = '{imm:3'd4, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b0, u2:1'b0};
    tbl[7'b0010111] = '{imm:3'd4, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b0, u2:1'b0};
    tbl[7'b0110011] = '{imm:3'd0, rw:1'b1, mr:1'b0, mw:1'b0, u1:1'b1, u2:1'b1};

    sweep = '{32'h00A00093, 32'h00112223, 32'h00208463, 32'h008000EF, 32'h123450B7};
    sweep_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    pool = '{7'b0000011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
             7'b1100011, 7'b1101111, 7'b0110111, 7'b0110011, 7'b1111111};

    // Reset held for two edges with a live fetch slot, then a third rst cycle checked.
    rst = 1'b1; bus.f_instr = 32'hDEAD_BEEF; bus.f_pc = 32'h100; bus.f_valid = 1'b1;
    bus.ex_redirect = 1'b0;
    @(posedge clk); @(posedge clk);
    model_reset();
    step(32'hDEAD_BEEF, 32'h100, 1'b1, 1'b0, 1'b1);
    cmp("rst_f_stall", 32'(bus.f_stall), 32'd0);
    cmp("rst_e_valid", 32'(bus.e_valid), 32'd0);
    cmp("rst_d_imm", 32'(bus.d_imm), 32'd0);
    cmp("rst_d_immsrc", 32'(bus.d_immsrc), 32'd0);
    cmp("rst_bubble", 32'(bus.bubble_st), 32'd0);

    // Immediate select sweep.
    for (int i = 0; i < 6; i++) begin
      step((i < 5) ? sweep[i] : NOP, 32'(4 * i), 1'b1, 1'b0, 1'b0);
      if (i >= 1) begin
        cmp("sweep_immsrc", 32'(bus.d_immsrc), 32'(sweep_sel[i-1]));
        cmp("sweep_imm", 32'(bus.d_imm), 32'(sweep[i-1][31:7]));
      end
      if (i >= 2) cmp("sweep_e_immsrc", 32'(bus.e_immsrc), 32'(sweep_sel[i-2]));
    end

    // Load-use: lw x5,0(x1); add x6,x5,x2.
    step(32'h0000A283, 32'h200, 1'b1, 1'b0, 1'b0);
    step(32'h00228333, 32'h204, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h208, 1'b1, 1'b0, 1'b0);
    cmp("lu_stall", 32'(bus.f_stall), 32'd1);
    step(NOP, 32'h208, 1'b1, 1'b0, 1'b0);
    cmp("lu_stall_len", 32'(bus.f_stall), 32'd0);
    cmp("lu_bubble_st", 32'(bus.bubble_st), 32'd1);
    cmp("lu_bubble_ev", 32'(bus.e_valid), 32'd0);
    step(NOP, 32'h20C, 1'b1, 1'b0, 1'b0);
    cmp("lu_add_rd", 32'(bus.e_rd), 32'd6);
    cmp("lu_add_rw", 32'(bus.e_regwrite), 32'd1);
    cmp("lu_add_ev", 32'(bus.e_valid), 32'd1);

    // lw x0 then add x6,x0,x2: no stall.
    step(32'h0000A003, 32'h300, 1'b1, 1'b0, 1'b0);
    step(32'h00200333, 32'h304, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h308, 1'b1, 1'b0, 1'b0);
    cmp("x0_nostall", 32'(bus.f_stall), 32'd0);

    // lw x5 then lui x5: U-type reads no registers.
    step(32'h0000A283, 32'h400, 1'b1, 1'b0, 1'b0);
    step(32'h123452B7, 32'h404, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h408, 1'b1, 1'b0, 1'b0);
    cmp("lui_nostall", 32'(bus.f_stall), 32'd0);

    // Redirect arriving in the hazard cycle wins over the stall.
    step(32'h0000A283, 32'h500, 1'b1, 1'b0, 1'b0);
    step(32'h00228333, 32'h504, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h508, 1'b1, 1'b1, 1'b0);
    cmp("redir_stall", 32'(bus.f_stall), 32'd0);
    step(NOP, 32'h600, 1'b1, 1'b0, 1'b0);
    cmp("redir_ev", 32'(bus.e_valid), 32'd0);
    cmp("redir_bub", 32'(bus.bubble_st), 32'd0);

    // Illegal opcode travels to EX without writes and without stalling.
    step(32'h0000007F, 32'h700, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h704, 1'b1, 1'b0, 1'b0);
    cmp("ill_stall", 32'(bus.f_stall), 32'd0);
    step(NOP, 32'h708, 1'b1, 1'b0, 1'b0);
    cmp("ill_ev", 32'(bus.e_valid), 32'd1);
    cmp("ill_flag", 32'(bus.e_illegal), 32'd1);
    cmp("ill_writes", 32'({bus.e_regwrite, bus.e_memread, bus.e_memwrite}), 32'd0);

    // Reset while in BUBBLE.
    step(32'h0000A283, 32'h800, 1'b1, 1'b0, 1'b0);
    step(32'h00228333, 32'h804, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h808, 1'b1, 1'b0, 1'b0);
    step(NOP, 32'h808, 1'b1, 1'b0, 1'b1);
    cmp("mrst_in_bubble", 32'(bus.bubble_st), 32'd1);
    step(NOP, 32'h900, 1'b1, 1'b0, 1'b0);
    cmp("mrst_bub", 32'(bus.bubble_st), 32'd0);
    cmp("mrst_ev", 32'(bus.e_valid), 32'd0);
    cmp("mrst_epc", bus.e_pc, 32'd0);
    cmp("mrst_ctrl", 32'({bus.e_rd, bus.e_immsrc, bus.e_regwrite, bus.e_memread,
                         bus.e_memwrite, bus.e_illegal}), 32'd0);

    // Random traffic with small register numbers so load-use pairs are common.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [31:0] pc;
      int          sel;
      ins = $urandom();
      sel = $urandom_range(0, 9);
      ins[6:0]   = pool[sel];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      pc = $urandom();
      step(ins, pc, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
